led_counter_uart_tx: RTL and testbench

//  Tiny-Tapeout-style user block: a 4-bit counter, shown on LEDs (uo_out[3:0]), advanced by a prescaled tick.

---
 rtl/led_counter_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_led_counter_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_counter_uart_tx.sv
// led_counter_uart_tx: 4-bit LED counter advanced by a prescaled tick; every
// count change (or a resend request) is sent as one ASCII hex char over a UART TX.
// Optional build macro: UART_PARITY_EN adds an even-parity bit (8E1 instead of 8N1).
module led_counter_uart_tx #(
    parameter int unsigned TICK_CYCLES  = 50_000_000,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Counter / prescaler state
    logic [PW-1:0] presc;
    logic [CW-1:0] count;
    logic          tick;
    logic          upd;
    logic          resend_q;

    // UART state
    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [DW-1:0] data, data_n;
    logic [DW-1:0] pend_char, pend_char_n;
    logic          pending, pending_n;
    logic          tx, tx_n;
    logic          busy, busy_n;

    logic          load_c, run_c, term_c, tick_c, req_c, baud_end_c, frame_end_c;
    logic [DW-1:0] req_char_c;
    logic          unused_ok;

    assign load_c     = ena & ui_in[3];
    assign run_c      = ena & ui_in[0];
    assign term_c     = (presc == PW'(TICK_CYCLES - 1));
    assign tick_c     = run_c & term_c & ~load_c;
    assign req_c      = upd | (ui_in[2] & ~resend_q);
    assign req_char_c = (count < CW'(10)) ? (8'h30 + DW'(count)) : (8'h37 + DW'(count));
    assign baud_end_c = (baud == BW'(CLKS_PER_BIT - 1));
    assign frame_end_c = (state == S_STOP) & baud_end_c;

    // Prescaler and counter: load beats tick beats hold; everything frozen while ena=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            count    <= '0;
            tick     <= 1'b0;
            upd      <= 1'b0;
            resend_q <= 1'b0;
        end else begin
            resend_q <= ui_in[2];
            tick     <= tick_c;
            upd      <= load_c | tick_c;
            if (load_c) begin
                count <= ui_in[7:4];
                presc <= '0;
            end else if (run_c) begin
                if (term_c) begin
                    presc <= '0;
                    count <= ui_in[1] ? (count - CW'(1)) : (count + CW'(1));
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    // UART state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            data      <= '0;
            pend_char <= '0;
            pending   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bit_idx   <= bit_idx_n;
            data      <= data_n;
            pend_char <= pend_char_n;
            pending   <= pending_n;
            tx        <= tx_n;
            busy      <= busy_n;
        end
    end

    // UART next state: frame sequencing, 1-deep latest-wins pending slot, registered line value
    always_comb begin
        state_n     = state;
        baud_n      = baud_end_c ? '0 : baud + BW'(1);
        bit_idx_n   = bit_idx;
        data_n      = data;
        pend_char_n = pend_char;
        pending_n   = pending;
        tx_n        = 1'b1;
        busy_n      = 1'b0;

        case (state)
            S_IDLE: begin
                baud_n = '0;
                if (req_c) begin
                    state_n = S_START;
                    data_n  = req_char_c;
                end
            end
            S_START: begin
                bit_idx_n = '0;
                if (baud_end_c) state_n = S_DATA;
            end
            S_DATA: begin
                if (baud_end_c) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_end_c) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_end_c) begin
                    pending_n = 1'b0;
                    if (req_c) begin
                        state_n = S_START;
                        data_n  = req_char_c;
                    end else if (pending) begin
                        state_n = S_START;
                        data_n  = pend_char;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A request arriving mid-frame parks in the pending slot, replacing any older one
        if (req_c && (state != S_IDLE) && !frame_end_c) begin
            pending_n   = 1'b1;
            pend_char_n = req_char_c;
        end

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = data_n[bit_idx_n];
`ifdef UART_PARITY_EN
            S_PARITY: tx_n = ^data_n;
`endif
            default:  tx_n = 1'b1;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    assign uo_out    = {pending, tick, busy, tx, count};
    assign uio_out   = '0;
    assign uio_oe    = '0;
    assign unused_ok = &{1'b0, uio_in};

endmodule

// File: tb/tb_led_counter_uart_tx.sv
// Testbench for led_counter_uart_tx: directed scenarios plus randomized traffic,
// checked every cycle against a frame-level behavioural model and a UART receiver.
module tb_led_counter_uart_tx;

    localparam int T = 8;
    localparam int C = 4;
`ifdef UART_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_checks = 0;
    int n_errors = 0;

    led_counter_uart_tx #(.TICK_CYCLES(T), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] m_count = 4'h0;
    int         m_presc = 0;
    logic       m_upd = 1'b0, m_tick = 1'b0, m_res_prev = 1'b0;
    logic       m_active = 1'b0, m_pend = 1'b0;
    int         m_off = 0;
    logic [7:0] m_fchar = 8'h00, m_pchar = 8'h00;
    logic [7:0] m_sent[$];
    logic [7:0] rx_q[$];

    function automatic logic [7:0] hexc(input logic [3:0] v);
        string s;
        s = "0123456789ABCDEF";
        return s[v];
    endfunction

    logic       m_req;
    logic [7:0] m_rch;
    assign m_req = m_upd | (ui_in[2] & ~m_res_prev);
    assign m_rch = hexc(m_count);

    // Line level from position inside the current frame
    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_off / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_fchar[b-1];
`ifdef UART_PARITY_EN
        if (b == 9) return ^m_fchar;
`endif
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_uo();
        return {m_pend, m_tick, m_active, exp_tx(), m_count};
    endfunction

    // Model update: frame schedule as an offset counter, counter as modular arithmetic
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count <= 4'h0; m_presc <= 0; m_upd <= 1'b0; m_tick <= 1'b0;
            m_res_prev <= 1'b0; m_active <= 1'b0; m_pend <= 1'b0; m_off <= 0;
        end else begin
            if (m_active && m_off == FL*C-1) begin
                if (m_req) begin
                    m_off <= 0; m_fchar <= m_rch; m_sent.push_back(m_rch);
                end else if (m_pend) begin
                    m_off <= 0; m_fchar <= m_pchar; m_sent.push_back(m_pchar);
                end else begin
                    m_active <= 1'b0;
                end
                m_pend <= 1'b0;
            end else if (m_active) begin
                m_off <= m_off + 1;
                if (m_req) begin m_pend <= 1'b1; m_pchar <= m_rch; end
            end else if (m_req) begin
                m_active <= 1'b1; m_off <= 0; m_fchar <= m_rch; m_sent.push_back(m_rch);
            end
            m_upd  <= 1'b0;
            m_tick <= 1'b0;
            if (ena) begin
                if (ui_in[3]) begin
                    m_count <= ui_in[7:4]; m_presc <= 0; m_upd <= 1'b1;
                end else if (ui_in[0]) begin
                    if (m_presc == T-1) begin
                        m_presc <= 0; m_tick <= 1'b1; m_upd <= 1'b1;
                        m_count <= 4'((int'(m_count) + (ui_in[1] ? 15 : 1)) % 16);
                    end else begin
                        m_presc <= m_presc + 1;
                    end
                end
            end
            m_res_prev <= ui_in[2];
        end
    end

    // ---------------- UART receiver (mid-bit sampling) ----------------
    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_on <= 1'b0; rx_cnt <= 0;
        end else if (!rx_on) begin
            if (uo_out[4] == 1'b0) begin rx_on <= 1'b1; rx_cnt <= 1; end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= C + C/2 && rx_cnt < 9*C && ((rx_cnt - C/2) % C) == 0)
                rx_byte[(rx_cnt - C/2)/C - 1] <= uo_out[4];
            if (rx_cnt == (FL-1)*C + C/2) begin
                rx_q.push_back(rx_byte);
                rx_on <= 1'b0;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ui_in = 8'h00; ena = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        n_checks++; if (uo_out !== 8'h10) begin n_errors++; $display("FAIL reset_uo: got %h expected 10", uo_out); end
        n_checks++; if (uio_out !== 8'h00) begin n_errors++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
        n_checks++; if (uio_oe !== 8'h00) begin n_errors++; $display("FAIL reset_uio_oe: got %h expected 00", uio_oe); end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== 8'h10) begin n_errors++; $display("FAIL reset_hold cyc %0d: got %h expected 10", i, uo_out); end
        end
    endtask

    task automatic test_load_frame();
        logic [FL-1:0] pat;
        int busy_cnt;
`ifdef UART_PARITY_EN
        pat = {1'b1, 1'b0, 8'h41, 1'b0};
`else
        pat = {1'b1, 8'h41, 1'b0};
`endif
        rx_q.delete(); m_sent.delete();
        ui_in = 8'hA8;
        @(negedge clk);
        n_checks++; if (uo_out[3:0] !== 4'hA) begin n_errors++; $display("FAIL load_a_count: got %h expected a", uo_out[3:0]); end
        ui_in = 8'h00;
        busy_cnt = 0;
        for (int i = 0; i < FL*C + 8; i++) begin
            @(negedge clk);
            if (uo_out[5] === 1'b1) busy_cnt++;
            n_checks++;
            if (uo_out[4] !== ((i < FL*C) ? pat[i/C] : 1'b1)) begin
                n_errors++; $display("FAIL load_a_tx cyc %0d: got %b expected %b", i, uo_out[4], (i < FL*C) ? pat[i/C] : 1'b1);
            end
            n_checks++;
            if (uo_out !== exp_uo()) begin n_errors++; $display("FAIL load_a_model cyc %0d: got %h expected %h", i, uo_out, exp_uo()); end
        end
        n_checks++; if (busy_cnt != FL*C) begin n_errors++; $display("FAIL load_a_busy_len: got %0d expected %0d", busy_cnt, FL*C); end
        n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin n_errors++; $display("FAIL load_a_rx: got %0d chars first %h expected 1 char 41", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    endtask

    task automatic test_wrap(input logic [7:0] load_v, input logic [7:0] run_v, input logic [3:0] wrap_to,
                             input logic [7:0] c0, input logic [7:0] c1, input string nm);
        rx_q.delete(); m_sent.delete();
        ui_in = load_v;
        @(negedge clk);
        n_checks++; if (uo_out[3:0] !== load_v[7:4]) begin n_errors++; $display("FAIL %s_load: got %h expected %h", nm, uo_out[3:0], load_v[7:4]); end
        ui_in = run_v;
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== exp_uo()) begin n_errors++; $display("FAIL %s_model cyc %0d: got %h expected %h", nm, i, uo_out, exp_uo()); end
        end
        n_checks++; if (uo_out[3:0] !== wrap_to) begin n_errors++; $display("FAIL %s_count: got %h expected %h", nm, uo_out[3:0], wrap_to); end
        n_checks++; if (uo_out[6] !== 1'b1) begin n_errors++; $display("FAIL %s_tick: got %b expected 1", nm, uo_out[6]); end
        ui_in = 8'h00;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== exp_uo()) begin n_errors++; $display("FAIL %s_drain cyc %0d: got %h expected %h", nm, i, uo_out, exp_uo()); end
        end
        n_checks++;
        if (rx_q.size() != 2 || rx_q[0] !== c0 || rx_q[1] !== c1) begin
            n_errors++; $display("FAIL %s_rx: got %0d chars expected %h then %h", nm, rx_q.size(), c0, c1);
        end
    endtask

    task automatic test_free_run();
        bit pend_seen;
        int gaps;
        rx_q.delete(); m_sent.delete();
        pend_seen = 0; gaps = 0;
        ui_in = 8'h01;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (uo_out[7] === 1'b1) pend_seen = 1;
            if (i >= 60 && uo_out[5] !== 1'b1) gaps++;
            n_checks++;
            if (uo_out !== exp_uo()) begin n_errors++; $display("FAIL free_run cyc %0d: got %h expected %h", i, uo_out, exp_uo()); end
        end
        ui_in = 8'h00;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== exp_uo()) begin n_errors++; $display("FAIL free_drain cyc %0d: got %h expected %h", i, uo_out, exp_uo()); end
        end
        n_checks++; if (!pend_seen) begin n_errors++; $display("FAIL free_pending: got 0 expected 1 seen"); end
        n_checks++; if (gaps != 0) begin n_errors++; $display("FAIL free_no_gap: got %0d idle cycles expected 0", gaps); end
        n_checks++; if (rx_q.size() < 9) begin n_errors++; $display("FAIL free_frames: got %0d expected >= 9", rx_q.size()); end
        n_checks++; if (rx_q.size() != m_sent.size()) begin n_errors++; $display("FAIL free_rx_len: got %0d expected %0d", rx_q.size(), m_sent.size()); end
        for (int k = 0; k < rx_q.size() && k < m_sent.size(); k++) begin
            n_checks++;
            if (rx_q[k] !== m_sent[k]) begin n_errors++; $display("FAIL free_rx_char %0d: got %h expected %h", k, rx_q[k], m_sent[k]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        ui_in = 8'h58;
        @(negedge clk);
        ui_in = 8'h00;
        repeat (20) @(negedge clk);
        n_checks++; if (uo_out[5] !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_busy: got %b expected 1", uo_out[5]); end
        rst = 1'b1;
        #1;
        n_checks++; if (uo_out !== 8'h10) begin n_errors++; $display("FAIL midrst_immediate: got %h expected 10", uo_out); end
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete(); m_sent.delete();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== 8'h10) begin n_errors++; $display("FAIL midrst_quiet cyc %0d: got %h expected 10", i, uo_out); end
        end
        n_checks++; if (rx_q.size() != 0) begin n_errors++; $display("FAIL midrst_no_frame: got %0d frames expected 0", rx_q.size()); end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic res;
        rx_q.delete(); m_sent.delete();
        res = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== exp_uo()) begin n_errors++; $display("FAIL random cyc %0d: got %h expected %h", i, uo_out, exp_uo()); end
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) res = ~res;
            v = 8'($urandom);
            v[0] = ($urandom_range(0, 7) != 0);
            v[1] = ui_in[1] ^ ($urandom_range(0, 99) == 0);
            v[2] = res;
            v[3] = ($urandom_range(0, 39) == 0);
            ui_in = v;
        end
        ena = 1'b1; ui_in = {4'h0, 1'b0, res, 2'b00};
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== exp_uo()) begin n_errors++; $display("FAIL random_drain cyc %0d: got %h expected %h", i, uo_out, exp_uo()); end
        end
        n_checks++; if (rx_q.size() != m_sent.size()) begin n_errors++; $display("FAIL random_rx_len: got %0d expected %0d", rx_q.size(), m_sent.size()); end
        for (int k = 0; k < rx_q.size() && k < m_sent.size(); k++) begin
            n_checks++;
            if (rx_q[k] !== m_sent[k]) begin n_errors++; $display("FAIL random_rx_char %0d: got %h expected %h", k, rx_q[k], m_sent[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_frame();
        test_wrap(8'hF8, 8'h01, 4'h0, 8'h46, 8'h30, "wrap_up");
        test_wrap(8'h08, 8'h03, 4'hF, 8'h30, 8'h46, "wrap_down");
        test_free_run();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
